// File: rtl/ts_bank_rr_arbiter.sv
// Round-robin arbiter that shares one TCDM bank port between N_CH masters, upstream of the
// bank's test-and-set bridge. Routes the 1-cycle-latency read response back to the winner.
module ts_bank_rr_arbiter #(
  parameter int unsigned N_CH           = 4,
  parameter int unsigned ADDR_MEM_WIDTH = 12,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BE_WIDTH       = DATA_WIDTH / 8,
  parameter int unsigned AUX_WIDTH      = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_CH-1:0]                m_req_i,
  input  logic [N_CH*ADDR_MEM_WIDTH-1:0] m_add_i,
  input  logic [N_CH-1:0]                m_ts_i,
  input  logic [N_CH-1:0]                m_wen_i,
  input  logic [N_CH*DATA_WIDTH-1:0]     m_wdata_i,
  input  logic [N_CH*BE_WIDTH-1:0]       m_be_i,
  input  logic [N_CH*AUX_WIDTH-1:0]      m_aux_i,
  output logic [N_CH-1:0]                m_gnt_o,
  output logic [N_CH-1:0]                m_r_valid_o,
  output logic [DATA_WIDTH-1:0]          m_r_rdata_o,
  output logic                           bridge_req_o,
  output logic [ADDR_MEM_WIDTH-1:0]      bridge_add_o,
  output logic                           bridge_ts_o,
  output logic                           bridge_wen_o,
  output logic [DATA_WIDTH-1:0]          bridge_wdata_o,
  output logic [BE_WIDTH-1:0]            bridge_be_o,
  output logic [N_CH-1:0]                bridge_ID_o,
  output logic [AUX_WIDTH-1:0]           bridge_aux_o,
  input  logic                           bridge_gnt_i,
  input  logic [DATA_WIDTH-1:0]          mem_rdata_i
);

  localparam int unsigned PtrW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [PtrW-1:0] r_rr_ptr_q;
  logic            r_valid_q;
  logic [N_CH-1:0] r_id_q;

  logic [PtrW-1:0] w_winner;
  logic [N_CH-1:0] w_onehot;
  logic            w_grant;

  // Winner is the requester with the smallest cyclic distance from the pointer;
  // with no requester the pointer itself selects the (don't-care) payload.
  always_comb begin
    int v_best;
    int v_off;
    w_winner = r_rr_ptr_q;
    v_best   = int'(N_CH);
    v_off    = 0;
    for (int j = 0; j < int'(N_CH); j++) begin
      v_off = j - int'(r_rr_ptr_q);
      if (v_off < 0) v_off = v_off + int'(N_CH);
      if (m_req_i[j] && (v_off < v_best)) begin
        v_best   = v_off;
        w_winner = PtrW'(j);
      end
    end
  end

  always_comb begin
    w_onehot       = '0;
    bridge_add_o   = '0;
    bridge_ts_o    = 1'b0;
    bridge_wen_o   = 1'b0;
    bridge_wdata_o = '0;
    bridge_be_o    = '0;
    bridge_aux_o   = '0;
    for (int j = 0; j < int'(N_CH); j++) begin
      if (w_winner == PtrW'(j)) begin
        w_onehot[j]    = 1'b1;
        bridge_add_o   = m_add_i[j*ADDR_MEM_WIDTH +: ADDR_MEM_WIDTH];
        bridge_ts_o    = m_ts_i[j];
        bridge_wen_o   = m_wen_i[j];
        bridge_wdata_o = m_wdata_i[j*DATA_WIDTH +: DATA_WIDTH];
        bridge_be_o    = m_be_i[j*BE_WIDTH +: BE_WIDTH];
        bridge_aux_o   = m_aux_i[j*AUX_WIDTH +: AUX_WIDTH];
      end
    end
  end

  assign bridge_req_o = |m_req_i;
  assign bridge_ID_o  = w_onehot;
  assign w_grant      = bridge_gnt_i & bridge_req_o;
  assign m_gnt_o      = w_onehot & {N_CH{w_grant}};

  // The bridge's set store is shielded simply by bridge_gnt_i being low: no grant, no response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr_q <= '0;
      r_valid_q  <= 1'b0;
      r_id_q     <= '0;
    end else begin
      r_valid_q <= w_grant;
      if (w_grant) begin
        r_id_q     <= w_onehot;
        r_rr_ptr_q <= (w_winner == PtrW'(N_CH - 1)) ? '0 : w_winner + 1'b1;
      end
    end
  end

  assign m_r_valid_o = r_id_q & {N_CH{r_valid_q}};
  assign m_r_rdata_o = mem_rdata_i;

endmodule
